bit_permute_pipe: RTL and testbench

//   Parametrised, pipelined successor to the FPA's fixed 32b select-reverse.
//   - Four permutation modes: pass, full reverse, reverse-within-group, group-order swap.
//   - Leading-zero count of the permuted word, for FPA/FPM mantissa normalisation.
//   - valid/ready handshake on both sides; full throughput; 2-cycle latency.
//   - Sits between the mantissa align stage and the normalise shifter.

---
 rtl/bit_permute_pipe_pkg.sv | 11 +
 rtl/bit_permute.sv | 41 ++++
 rtl/bit_permute_pipe.sv | 79 +++++++
 tb/tb_bit_permute_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_permute_pipe_pkg.sv
// Shared permutation mode encodings for the bit-permute pipeline and the FPA/FPM control.
package bit_permute_pipe_pkg;

    typedef enum logic [1:0] {
        BP_PASS  = 2'b00,
        BP_REV   = 2'b01,
        BP_GREV  = 2'b10,
        BP_GSWAP = 2'b11
    } bp_mode_e;

endpackage

// File: rtl/bit_permute.sv
// Combinational word permutation: pass, full reverse, reverse within group, group-order swap.
module bit_permute
    import bit_permute_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GRP   = 8
) (
    input  logic [WIDTH-1:0] x,
    input  bp_mode_e         mode,
    output logic [WIDTH-1:0] c
);

    localparam int unsigned NGRP = WIDTH / GRP;

    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] grev;
    logic [WIDTH-1:0] gswap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev[i] = x[WIDTH-1-i];
    end

    // Group g keeps its slot for grev; gswap moves it whole to slot NGRP-1-g.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        for (genvar j = 0; j < GRP; j++) begin : g_bit
            assign grev[g*GRP + j]            = x[g*GRP + GRP-1-j];
            assign gswap[(NGRP-1-g)*GRP + j]  = x[g*GRP + j];
        end
    end

    always_comb begin
        c = x;
        case (mode)
            BP_REV:   c = rev;
            BP_GREV:  c = grev;
            BP_GSWAP: c = gswap;
            default:  c = x;
        endcase
    end

endmodule

// File: rtl/bit_permute_pipe.sv
// Two-stage bit permutation pipeline with leading-zero count and valid/ready handshake.
module bit_permute_pipe
    import bit_permute_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GRP   = 8,
    parameter int unsigned LZW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LZW-1:0]   out_lz
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [WIDTH-1:0] perm_c;
    logic [LZW-1:0]   lz_c;
    logic             adv1;
    logic             adv2;

    // S2 drains when empty or accepted; S1 may refill whenever S2 will take its word.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    bit_permute #(
        .WIDTH (WIDTH),
        .GRP   (GRP)
    ) u_perm (
        .x    (in_data),
        .mode (bp_mode_e'(in_mode)),
        .c    (perm_c)
    );

    // Priority chain: the highest set bit of the S1 word overrides every lower one.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lz
        logic [LZW-1:0] cnt;
        if (i == 0) begin : g_first
            assign cnt = s1_data[0] ? LZW'(WIDTH - 1) : LZW'(WIDTH);
        end else begin : g_next
            assign cnt = s1_data[i] ? LZW'(WIDTH - 1 - i) : g_lz[i-1].cnt;
        end
    end
    assign lz_c = g_lz[WIDTH-1].cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= perm_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lz    <= LZW'(WIDTH);
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_data;
                out_lz   <= lz_c;
            end
        end
    end

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Bench for bit_permute_pipe: three configurations checked against a software permutation model.
module tb_bit_permute_pipe;

    logic        clk;
    logic        reset;
    bit          rand_en;
    logic        dir_valid;
    logic        dir_ready;
    logic [1:0]  dir_mode;
    logic [31:0] dir_data;
    int          tests;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Source bit for each destination bit, straight from the mode definitions.
    function automatic logic [31:0] model_perm(logic [31:0] d, logic [1:0] m, int w, int g);
        logic [31:0] r;
        int src;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                2'b01:   src = w - 1 - i;
                2'b10:   src = (i / g) * g + (g - 1 - (i % g));
                2'b11:   src = (w / g - 1 - i / g) * g + (i % g);
                default: src = i;
            endcase
            r[i] = d[src];
        end
        return r;
    endfunction

    function automatic int model_lz(logic [31:0] d, int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return w - 1 - i;
        end
        return w;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : cfg
        localparam int W = (k == 0) ? 32 : ((k == 1) ? 24 : 8);
        localparam int G = (k == 0) ? 8  : ((k == 1) ? 3  : 1);
        localparam int L = $clog2(W + 1);

        logic          in_valid;
        logic          in_ready;
        logic [1:0]    in_mode;
        logic [W-1:0]  in_data;
        logic          out_valid;
        logic          out_ready;
        logic [W-1:0]  out_data;
        logic [L-1:0]  out_lz;
        logic [31:0]   q[$];
        bit            held;
        logic [31:0]   hd;
        logic [31:0]   hl;
        int            delivered;

        bit_permute_pipe #(
            .WIDTH (W),
            .GRP   (G)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_mode   (in_mode),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_lz    (out_lz)
        );

        initial begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            in_mode   = 2'b00;
            in_data   = '0;
            held      = 1'b0;
            delivered = 0;
        end

        always @(negedge clk) begin
            if (rand_en) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 9) < 7);
                in_mode   = 2'($urandom);
                in_data   = W'($urandom);
            end else if (k == 0) begin
                in_valid  = dir_valid;
                out_ready = dir_ready;
                in_mode   = dir_mode;
                in_data   = W'(dir_data);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
        end

        // Words in flight = queue depth; input may stall only with two held and no accept.
        always @(negedge clk) begin
            #1;
            if (!reset) begin
                check($sformatf("cfg%0d in_ready", k), 32'(in_ready),
                      32'((q.size() < 2) || out_ready));
                if (held) begin
                    check($sformatf("cfg%0d hold valid", k), 32'(out_valid), 32'd1);
                    check($sformatf("cfg%0d hold data", k), 32'(out_data), hd);
                    check($sformatf("cfg%0d hold lz", k), 32'(out_lz), hl);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("cfg%0d unexpected output", k), 32'(out_valid), 32'd0);
                    end else begin
                        logic [31:0] e;
                        e = q.pop_front();
                        check($sformatf("cfg%0d data", k), 32'(out_data), e);
                        check($sformatf("cfg%0d lz", k), 32'(out_lz), 32'(model_lz(e, W)));
                        delivered++;
                    end
                end
                held = out_valid && !out_ready;
                hd   = 32'(out_data);
                hl   = 32'(out_lz);
                if (in_valid && in_ready) begin
                    q.push_back(model_perm(32'(in_data), in_mode, W, G));
                end
            end
        end

        always @(posedge reset) begin
            q.delete();
            held = 1'b0;
        end
    end

    task automatic dir_one(input string name, input logic [31:0] d, input logic [1:0] m,
                           input logic [31:0] exp_d, input logic [31:0] exp_lz);
        @(posedge clk); #1;
        dir_valid = 1'b1;
        dir_data  = d;
        dir_mode  = m;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        check({name, " early valid"}, 32'(cfg[0].out_valid), 32'd0);
        @(posedge clk); #1;
        check({name, " valid"}, 32'(cfg[0].out_valid), 32'd1);
        check({name, " data"}, 32'(cfg[0].out_data), exp_d);
        check({name, " lz"}, 32'(cfg[0].out_lz), exp_lz);
    endtask

    // Present one word and wait, bounded, until it is taken.
    task automatic send(input logic [31:0] d, input logic [1:0] m);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        dir_valid = 1'b1;
        dir_data  = d;
        dir_mode  = m;
        while (!acc && n < 20) begin
            @(negedge clk); #2;
            acc = cfg[0].in_ready;
            @(posedge clk); #1;
            n++;
        end
        check("send accepted", 32'(acc), 32'd1);
    endtask

    initial begin
        int d0;
        reset     = 1'b0;
        rand_en   = 1'b0;
        dir_valid = 1'b0;
        dir_ready = 1'b1;
        dir_mode  = 2'b00;
        dir_data  = '0;
        tests     = 0;
        fails     = 0;

        #2 reset = 1'b1;
        #1;
        check("reset valid", 32'(cfg[0].out_valid), 32'd0);
        check("reset data", 32'(cfg[0].out_data), 32'd0);
        check("reset lz", 32'(cfg[0].out_lz), 32'd32);
        check("reset lz w8", 32'(cfg[2].out_lz), 32'd8);
        #19 reset = 1'b0;

        dir_one("rev one", 32'h0000_0001, 2'b01, 32'h8000_0000, 32'd0);
        dir_one("grev", 32'h0102_0304, 2'b10, 32'h8040_C020, 32'd0);
        dir_one("gswap", 32'h1122_3344, 2'b11, 32'h4433_2211, 32'd1);
        dir_one("zero", 32'h0000_0000, 2'b00, 32'h0000_0000, 32'd32);
        dir_one("rev msb", 32'h8000_0000, 2'b01, 32'h0000_0001, 32'd31);

        // Stall: A and B fill the pipe, C waits, A is held on the output.
        @(posedge clk); #1;
        d0 = cfg[0].delivered;
        dir_ready = 1'b0;
        send(32'hF0F0_0001, 2'b01);
        send(32'h1234_5678, 2'b00);
        dir_data = 32'hDEAD_BEEF;
        dir_mode = 2'b10;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall in_ready", 32'(cfg[0].in_ready), 32'd0);
            check("stall A data", 32'(cfg[0].out_data), 32'h8000_0F0F);
            check("stall A lz", 32'(cfg[0].out_lz), 32'd0);
        end
        dir_ready = 1'b1;
        send(32'hDEAD_BEEF, 2'b10);
        send(32'h0000_00F0, 2'b11);
        dir_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stream delivered", 32'(cfg[0].delivered - d0), 32'd4);
        check("stream drained", 32'(cfg[0].q.size()), 32'd0);

        // Asynchronous reset with two words in flight.
        dir_ready = 1'b0;
        send(32'h0000_0F00, 2'b00);
        send(32'hAAAA_5555, 2'b01);
        dir_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("async rst valid", 32'(cfg[0].out_valid), 32'd0);
        check("async rst lz", 32'(cfg[0].out_lz), 32'd32);
        check("async rst data", 32'(cfg[0].out_data), 32'd0);
        check("async rst s1", 32'(cfg[0].dut.s1_valid), 32'd0);
        #12 reset = 1'b0;
        @(posedge clk); #1;
        check("post rst in_ready", 32'(cfg[0].in_ready), 32'd1);
        check("post rst valid", 32'(cfg[0].out_valid), 32'd0);
        dir_ready = 1'b1;

        rand_en = 1'b1;
        repeat (3000) @(posedge clk);
        rand_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("drain cfg0", 32'(cfg[0].q.size()), 32'd0);
        check("drain cfg1", 32'(cfg[1].q.size()), 32'd0);
        check("drain cfg2", 32'(cfg[2].q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
